// File: rtl/conv_window_scheduler_pkg.sv
// Shared encodings and default widths for the convolution window scheduler,
// its address generator and the blocks that talk to it.
package conv_window_scheduler_pkg;

  localparam int FILT_ADDR_LEN = 4;
  localparam int IF_ADDR_LEN   = 4;
  localparam int WIN_CNT_LEN   = 6;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_WAIT = 3'd1;
  localparam state_t ST_MAC  = 3'd2;
  localparam state_t ST_PSUM = 3'd3;
  localparam state_t ST_ADV  = 3'd4;

endpackage

// File: rtl/conv_window_scheduler_if.sv
// Control/address bundle between the top controller (master) and the window
// scheduler (slave); the scratchpad and MAC-side strobes ride along.
interface conv_window_scheduler_if #(
  parameter int FILT_ADDR_LEN = conv_window_scheduler_pkg::FILT_ADDR_LEN,
  parameter int IF_ADDR_LEN   = conv_window_scheduler_pkg::IF_ADDR_LEN,
  parameter int WIN_CNT_LEN   = conv_window_scheduler_pkg::WIN_CNT_LEN
);
  logic                     start_rd_gen;
  logic                     clr;
  logic [FILT_ADDR_LEN:0]   filter_size;
  logic [IF_ADDR_LEN-1:0]   stride;
  logic [WIN_CNT_LEN-1:0]   num_windows;
  logic [IF_ADDR_LEN:0]     if_avail;
  logic                     filt_valid;
  logic                     psum_ready;

  logic [IF_ADDR_LEN-1:0]   if_raddr;
  logic [FILT_ADDR_LEN-1:0] filt_raddr;
  logic                     mac_en;
  logic                     mac_valid;
  logic                     mac_last;
  logic                     if_consume;
  logic [IF_ADDR_LEN-1:0]   consume_cnt;
  logic                     psum_done;
  logic                     stride_count_flag;
  logic                     full_done;
  logic                     busy;

  modport master (
    output start_rd_gen, clr, filter_size, stride, num_windows,
           if_avail, filt_valid, psum_ready,
    input  if_raddr, filt_raddr, mac_en, mac_valid, mac_last, if_consume,
           consume_cnt, psum_done, stride_count_flag, full_done, busy
  );

  modport slave (
    input  start_rd_gen, clr, filter_size, stride, num_windows,
           if_avail, filt_valid, psum_ready,
    output if_raddr, filt_raddr, mac_en, mac_valid, mac_last, if_consume,
           consume_cnt, psum_done, stride_count_flag, full_done, busy
  );
endinterface

// File: rtl/conv_window_scheduler_window_addr_gen.sv
// Window address generator: circular IF base pointer plus tap counter,
// producing IF and filter scratchpad read addresses.
module window_addr_gen #(
  parameter int FILT_ADDR_LEN = conv_window_scheduler_pkg::FILT_ADDR_LEN,
  parameter int IF_ADDR_LEN   = conv_window_scheduler_pkg::IF_ADDR_LEN
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     load,
  input  logic                     step,
  input  logic                     advance,
  input  logic [IF_ADDR_LEN-1:0]   stride,
  output logic [IF_ADDR_LEN-1:0]   if_raddr,
  output logic [FILT_ADDR_LEN-1:0] filt_raddr
);
  logic [IF_ADDR_LEN-1:0]   if_base;
  logic [FILT_ADDR_LEN-1:0] k;

  // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_base <= '0;
      k       <= '0;
    end else if (clr) begin
      if_base <= '0;
      k       <= '0;
    end else begin
      if (load)      k <= '0;
      else if (step) k <= k + 1'b1;
      if (advance)   if_base <= if_base + stride;
    end
  end

  // Sum truncated to the IF width gives the circular-buffer wrap for free.
  assign if_raddr   = if_base + IF_ADDR_LEN'(k);
  assign filt_raddr = k;
endmodule

// File: rtl/conv_window_scheduler.sv
// Per-window MAC sequencer: waits for operands, streams filter_size taps,
// hands the psum off, then strides the IF window until the row is done.
module conv_window_scheduler #(
  parameter int FILT_ADDR_LEN = conv_window_scheduler_pkg::FILT_ADDR_LEN,
  parameter int IF_ADDR_LEN   = conv_window_scheduler_pkg::IF_ADDR_LEN,
  parameter int WIN_CNT_LEN   = conv_window_scheduler_pkg::WIN_CNT_LEN
) (
  input logic                    clk,
  input logic                    rst,
  conv_window_scheduler_if.slave bus
);
  import conv_window_scheduler_pkg::*;

  state_t                   state, state_nxt;
  logic [FILT_ADDR_LEN:0]   fs_l;
  logic [IF_ADDR_LEN-1:0]   stride_l;
  logic [WIN_CNT_LEN-1:0]   nw_l, w;
  logic [FILT_ADDR_LEN-1:0] filt_raddr;
  logic                     start_acc, go, tap_last, win_last;
  logic                     load_k, step_k, adv;
  logic                     mac_en, psum_done, full_done;
  logic                     mac_valid_q, mac_last_q;

  assign start_acc = bus.start_rd_gen && (state == ST_IDLE);
  assign go        = bus.filt_valid && (bus.if_avail >= fs_l);
  assign tap_last  = ({1'b0, filt_raddr} == fs_l - 1'b1);
  assign win_last  = (w == nw_l - 1'b1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch forms.
    state_nxt = state;
    if (bus.clr) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (bus.start_rd_gen) state_nxt = ST_WAIT;
        ST_WAIT: if (go)               state_nxt = ST_MAC;
        ST_MAC:  if (tap_last)         state_nxt = ST_PSUM;
        ST_PSUM: if (bus.psum_ready)   state_nxt = ST_ADV;
        ST_ADV:  state_nxt = win_last ? ST_IDLE : ST_WAIT;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    mac_en    = 1'b0;
    load_k    = 1'b0;
    step_k    = 1'b0;
    adv       = 1'b0;
    psum_done = 1'b0;
    full_done = 1'b0;
    case (state)
      ST_WAIT: load_k = go;
      ST_MAC: begin
        mac_en = 1'b1;
        step_k = 1'b1;
      end
      ST_PSUM: psum_done = bus.psum_ready;
      ST_ADV: begin
        adv       = 1'b1;
        full_done = win_last;
      end
      default: ;
    endcase
  end

  // Zero size/stride/count are promoted to 1 so a row always makes progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fs_l     <= '0;
      stride_l <= '0;
      nw_l     <= '0;
      w        <= '0;
    end else if (bus.clr) begin
      w <= '0;
    end else if (start_acc) begin
      fs_l     <= (bus.filter_size == '0) ? (FILT_ADDR_LEN+1)'(1) : bus.filter_size;
      stride_l <= (bus.stride == '0)      ? IF_ADDR_LEN'(1)       : bus.stride;
      nw_l     <= (bus.num_windows == '0) ? WIN_CNT_LEN'(1)       : bus.num_windows;
      w        <= '0;
    end else if (adv && !win_last) begin
      w <= w + 1'b1;
    end
  end

  // One-cycle delay lines up the MAC qualifiers with scratchpad read data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mac_valid_q <= 1'b0;
      mac_last_q  <= 1'b0;
    end else if (bus.clr) begin
      mac_valid_q <= 1'b0;
      mac_last_q  <= 1'b0;
    end else begin
      mac_valid_q <= mac_en;
      mac_last_q  <= mac_en && tap_last;
    end
  end

  window_addr_gen #(
    .FILT_ADDR_LEN(FILT_ADDR_LEN),
    .IF_ADDR_LEN  (IF_ADDR_LEN)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .clr       (bus.clr),
    .load      (load_k),
    .step      (step_k),
    .advance   (adv),
    .stride    (stride_l),
    .if_raddr  (bus.if_raddr),
    .filt_raddr(filt_raddr)
  );

  assign bus.filt_raddr        = filt_raddr;
  assign bus.mac_en            = mac_en;
  assign bus.mac_valid         = mac_valid_q;
  assign bus.mac_last          = mac_last_q;
  assign bus.if_consume        = adv;
  assign bus.consume_cnt       = stride_l;
  assign bus.psum_done         = psum_done;
  assign bus.stride_count_flag = adv;
  assign bus.full_done         = full_done;
  assign bus.busy              = (state != ST_IDLE);
endmodule

// File: tb/tb_conv_window_scheduler.sv
// Self-checking bench for conv_window_scheduler: directed and randomized rows
// compared against a window/tap model derived from plain address arithmetic.
module tb_conv_window_scheduler;
  import conv_window_scheduler_pkg::*;

  localparam int DEPTH = 1 << IF_ADDR_LEN;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  int   model_base = 0;

  conv_window_scheduler_if bus ();

  conv_window_scheduler dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({bus.if_raddr, bus.filt_raddr, bus.mac_en, bus.mac_valid, bus.mac_last,
                bus.if_consume, bus.consume_cnt, bus.psum_done, bus.stride_count_flag,
                bus.full_done, bus.busy});
  endfunction

  // One row pass: taps/addresses from the window model, event timing from
  // window length arithmetic (WAIT + filter_size MAC + PSUM + ADV per window).
  task automatic run_row(input int fs, input int st, input int nw, input int stall,
                         input int short_wait, input string tag);
    int fs_e   = (fs == 0) ? 1 : fs;
    int st_e   = (st == 0) ? 1 : st;
    int nw_e   = (nw == 0) ? 1 : nw;
    int n_taps = fs_e * nw_e;
    int avail  = (short_wait > 0) ? fs_e - 1 : fs_e + int'($urandom_range(0, DEPTH - fs_e));
    int idx = 0, cyc = 0, busy_cyc = 0, psums = 0, strides = 0, fulls = 0;
    int full_cyc = 0, first_mac = 0, last_tap_cyc = 0, psum_cyc = -10, left = 0;
    bit prev_en = 1'b0, prev_last = 1'b0, pend = 1'b0, done = 1'b0, exp_adv;

    bus.filter_size  = (FILT_ADDR_LEN+1)'(fs);
    bus.stride       = IF_ADDR_LEN'(st);
    bus.num_windows  = WIN_CNT_LEN'(nw);
    bus.if_avail     = (IF_ADDR_LEN+1)'(avail);
    bus.psum_ready   = 1'b1;
    bus.start_rd_gen = 1'b1;
    @(posedge clk); #1;
    bus.start_rd_gen = 1'b0;
    bus.filter_size  = (FILT_ADDR_LEN+1)'($urandom);
    bus.stride       = IF_ADDR_LEN'($urandom);
    bus.num_windows  = WIN_CNT_LEN'($urandom);

    while (!done && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      exp_adv = (cyc == psum_cyc + 1);
      check({tag, " mac_valid"}, 32'(bus.mac_valid), 32'(prev_en));
      check({tag, " mac_last"}, 32'(bus.mac_last), 32'(prev_last));
      prev_last = 1'b0;
      if (bus.mac_en) begin
        if (first_mac == 0) first_mac = cyc;
        if (idx < n_taps) begin
          check({tag, " if_raddr"}, 32'(bus.if_raddr),
                32'((model_base + (idx / fs_e) * st_e + idx % fs_e) % DEPTH));
          check({tag, " filt_raddr"}, 32'(bus.filt_raddr), 32'(idx % fs_e));
          prev_last = (idx % fs_e == fs_e - 1);
          if (prev_last) begin
            last_tap_cyc = cyc;
            pend = (stall > 0);
          end
        end else begin
          check({tag, " extra mac_en"}, 32'(bus.mac_en), 32'(0));
        end
        idx++;
      end
      prev_en = bus.mac_en;
      if (bus.psum_done) begin
        psums++;
        psum_cyc = cyc;
        check({tag, " psum latency"}, 32'(cyc - last_tap_cyc), 32'(1 + stall));
      end
      check({tag, " stride_count_flag"}, 32'(bus.stride_count_flag), 32'(exp_adv));
      check({tag, " if_consume"}, 32'(bus.if_consume), 32'(exp_adv));
      check({tag, " full_done"}, 32'(bus.full_done), 32'(exp_adv && strides == nw_e - 1));
      if (exp_adv) begin
        strides++;
        check({tag, " consume_cnt"}, 32'(bus.consume_cnt), 32'(st_e));
      end
      if (bus.full_done) begin
        fulls++;
        full_cyc = cyc;
      end
      if (bus.busy) busy_cyc++;
      else          done = 1'b1;

      if (!done) begin
        @(posedge clk); #1;
        bus.start_rd_gen = (cyc == 3);
        if (short_wait > 0 && cyc == short_wait) bus.if_avail = (IF_ADDR_LEN+1)'(fs_e);
        if (pend) begin
          bus.psum_ready = 1'b0;
          left = stall;
          pend = 1'b0;
        end else if (left > 0) begin
          left--;
          if (left == 0) bus.psum_ready = 1'b1;
        end
      end
    end

    check({tag, " row finished"}, 32'(done), 32'(1));
    check({tag, " tap count"}, 32'(idx), 32'(n_taps));
    check({tag, " psum count"}, 32'(psums), 32'(nw_e));
    check({tag, " stride count"}, 32'(strides), 32'(nw_e));
    check({tag, " full_done count"}, 32'(fulls), 32'(1));
    check({tag, " busy falls after full_done"}, 32'(full_cyc), 32'(busy_cyc));
    check({tag, " row length"}, 32'(busy_cyc), 32'(nw_e * (fs_e + 3 + stall) + short_wait));
    if (short_wait > 0) check({tag, " first mac cycle"}, 32'(first_mac), 32'(short_wait + 2));
    model_base = (model_base + nw_e * st_e) % DEPTH;
  endtask

  initial begin
    bus.start_rd_gen = 1'b0;
    bus.clr          = 1'b0;
    bus.filter_size  = '0;
    bus.stride       = '0;
    bus.num_windows  = '0;
    bus.if_avail     = (IF_ADDR_LEN+1)'(DEPTH);
    bus.filt_valid   = 1'b1;
    bus.psum_ready   = 1'b1;

    #12;
    check("outputs in reset", outs(), 32'(0));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("idle after reset", outs(), 32'(0));

    run_row(3, 1, 2, 0, 0, "basic");
    run_row(3, 2, 1, 0, 4, "if_avail");
    run_row(2, 1, 2, 4, 0, "psum_stall");

    // Abort during the second MAC cycle.
    bus.filter_size  = (FILT_ADDR_LEN+1)'(3);
    bus.stride       = IF_ADDR_LEN'(1);
    bus.num_windows  = WIN_CNT_LEN'(2);
    bus.start_rd_gen = 1'b1;
    @(posedge clk); #1;
    bus.start_rd_gen = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("clr first tap mac_en", 32'(bus.mac_en), 32'(1));
    @(posedge clk); #1;
    bus.clr = 1'b1;
    @(negedge clk);
    check("clr second tap addr", 32'(bus.if_raddr), 32'((model_base + 1) % DEPTH));
    @(posedge clk); #1;
    bus.clr = 1'b0;
    @(negedge clk);
    check("clr busy", 32'(bus.busy), 32'(0));
    check("clr mac_en", 32'(bus.mac_en), 32'(0));
    check("clr mac_valid", 32'(bus.mac_valid), 32'(0));
    check("clr base zero", 32'(bus.if_raddr), 32'(0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("clr no psum_done", 32'(bus.psum_done), 32'(0));
    end
    model_base = 0;

    run_row(1, 7, 1, 0, 0, "preset_a");
    run_row(1, 7, 1, 0, 0, "preset_b");
    run_row(3, 1, 1, 0, 0, "wrap");

    // Asynchronous reset in the middle of a window.
    bus.filter_size  = (FILT_ADDR_LEN+1)'(4);
    bus.stride       = IF_ADDR_LEN'(2);
    bus.num_windows  = WIN_CNT_LEN'(2);
    bus.start_rd_gen = 1'b1;
    @(posedge clk); #1;
    bus.start_rd_gen = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre-reset mac_en", 32'(bus.mac_en), 32'(1));
    #2 rst = 1'b0;
    #1 check("async reset outputs", outs(), 32'(0));
    @(negedge clk);
    check("held reset outputs", outs(), 32'(0));
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("after reset outputs", outs(), 32'(0));
    end
    model_base = 0;
    run_row(0, 0, 3, 0, 0, "post_rst");

    for (int r = 0; r < 8; r++) begin
      run_row(int'($urandom_range(0, 8)), int'($urandom_range(0, 15)),
              int'($urandom_range(0, 4)), int'($urandom_range(0, 2)),
              int'($urandom_range(0, 3)), "random");
    end

    // Start and clr together: clr wins.
    bus.filter_size  = (FILT_ADDR_LEN+1)'(2);
    bus.stride       = IF_ADDR_LEN'(3);
    bus.num_windows  = WIN_CNT_LEN'(1);
    bus.start_rd_gen = 1'b1;
    bus.clr          = 1'b1;
    @(posedge clk); #1;
    bus.start_rd_gen = 1'b0;
    bus.clr          = 1'b0;
    @(negedge clk);
    check("start+clr busy", 32'(bus.busy), 32'(0));
    model_base = 0;
    run_row(2, 3, 1, 0, 0, "after_start_clr");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/conv_window_scheduler.md
Name: conv_window_scheduler

Overview:
- Sequences the per-window MAC pass of the convolution datapath.
- On a `start_rd_gen` pulse from the top controller, walks filter-sized windows across the IF scratchpad.
  - Generates the IF and filter read addresses and a MAC enable.
  - Reports end of window (`psum_done`), window advance (`stride_count_flag`) and end of row (`full_done`) back to the top controller.
- Sits between the top controller and the IF/filter scratchpads plus the MAC/psum unit.

Parameters:
- FILT_ADDR_LEN, 4: filter scratchpad address width; filter size is 1..2^FILT_ADDR_LEN.
- IF_ADDR_LEN, 4: IF scratchpad address width; the IF buffer is circular, depth 2^IF_ADDR_LEN.
- WIN_CNT_LEN, 6: width of the windows-per-row counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start_rd_gen  in  1  one-cycle pulse: begin a row pass.
- clr  in  1  synchronous abort: return to IDLE and zero all pointers and counters.
- filter_size  in  FILT_ADDR_LEN+1  taps per window; sampled on start.
- stride  in  IF_ADDR_LEN  window advance; sampled on start.
- num_windows  in  WIN_CNT_LEN  windows per row; sampled on start.
- if_avail  in  IF_ADDR_LEN+1  valid IF words counted from the current base.
- filt_valid  in  1  filter scratchpad loaded.
- psum_ready  in  1  psum sink can accept a result.
- if_raddr  out  IF_ADDR_LEN  IF read address.
- filt_raddr  out  FILT_ADDR_LEN  filter read address.
- mac_en  out  1  addresses valid this cycle.
- mac_valid  out  1  `mac_en` delayed one cycle; aligns with scratchpad read data.
- mac_last  out  1  qualifies the last tap; aligned with `mac_valid`.
- if_consume  out  1  pulse: the IF buffer may free `consume_cnt` words.
- consume_cnt  out  IF_ADDR_LEN  equals the latched stride.
- psum_done  out  1  one-cycle pulse.
- stride_count_flag  out  1  one-cycle pulse.
- full_done  out  1  one-cycle pulse.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (`rst`=0, async):
  - State goes to IDLE.
  - `if_base`, tap counter `k` and window counter `w` are cleared.
  - All outputs are 0.
- Configuration sampled on start:
  - `filter_size`=0 is latched as 1.
  - `stride`=0 is latched as 1.
  - `num_windows`=0 is latched as 1.
- IDLE:
  - On `start_rd_gen`: latch the configuration, set `w`=0, go to WAIT.
  - `if_base` is not cleared on start; it persists across rows. Only reset or `clr` zero it.
- WAIT:
  - Go to MAC when `filt_valid`=1 and `if_avail` >= latched `filter_size`; set `k`=0.
  - Otherwise hold, with all strobes at 0.
- MAC:
  - `mac_en`=1.
  - `if_raddr` = (`if_base`+`k`) mod 2^IF_ADDR_LEN.
  - `filt_raddr` = `k`.
  - `k` increments each cycle.
  - When `k` = `filter_size`-1, go to PSUM.
  - A window therefore takes exactly `filter_size` MAC cycles with no bubbles.
- PSUM:
  - If `psum_ready`=1: pulse `psum_done` for one cycle and go to ADV.
  - Otherwise hold; `psum_done` stays 0.
- ADV (single cycle):
  - Pulse `stride_count_flag` and `if_consume`.
  - `if_base` += stride, with mod 2^IF_ADDR_LEN wrap.
  - If `w` = `num_windows`-1: pulse `full_done` in the same cycle and go to IDLE.
  - Otherwise `w`++ and go to WAIT.
- Output pipeline:
  - `mac_valid` and `mac_last` are registered copies of `mac_en` and (`mac_en` && `k`==`filter_size`-1). They are valid one cycle after the address.
  - All other outputs are decoded from state and counters.
- `start_rd_gen` while `busy`: ignored, with no restart and no relatch.
- `clr`:
  - Has priority over every transition.
  - Next cycle: IDLE, zero pointers/counters, `mac_en`=0.
  - The pipeline register is also cleared, so `mac_valid` is 0 on the cycle after `clr`.
- Async reset mid-MAC: outputs drop immediately; no `psum_done` is emitted.
- Simultaneous `start_rd_gen` and `clr`: `clr` wins and the block stays in IDLE.
- Address wrap: `if_raddr` wraps modulo the IF depth within a window; e.g. base 14, size 3, depth 16 gives 14, 15, 0.

Decomposition:
- Shared package:
  - State encoding (IDLE, WAIT, MAC, PSUM, ADV as 3-bit localparams).
  - Default widths FILT_ADDR_LEN, IF_ADDR_LEN, WIN_CNT_LEN, shared with the top controller and the scratchpads.
- One natural sub-module: `window_addr_gen`.
  - Holds `if_base`, `k` and the wrap adder.
  - Produces `if_raddr`/`filt_raddr`.
  - Is driven by load/step/advance strobes from the FSM.

Test Plan:
- Size 3, stride 1, 2 windows, `if_avail`=8, `filt_valid`=1, `psum_ready`=1, start:
  - `mac_en` high 3 cycles with IF addresses 0,1,2 and filter 0,1,2.
  - `psum_done` then `stride_count_flag`.
  - Second window uses IF addresses 1,2,3.
  - `full_done` coincides with the second `stride_count_flag`; `busy` falls next cycle.
- `if_avail`=2 with size 3:
  - Holds in WAIT with `mac_en`=0.
  - Raising `if_avail` to 3 starts MAC on the next cycle.
- `psum_ready`=0 for 4 cycles after the last tap:
  - `psum_done` is delayed exactly 4 cycles.
  - No extra `mac_en`.
- Base wrap: preset `if_base`=14 via two rows of stride 7, then size 3:
  - IF addresses 14, 15, 0.
  - `mac_last` accompanies the third `mac_valid`.
- `clr` in the 2nd MAC cycle:
  - Next cycle `busy`=0, `mac_en`=0, `if_base`=0.
  - No `psum_done`.
  - A subsequent start begins at IF address 0.
- Async `rst` low mid-window:
  - All outputs are 0 immediately.
  - After release, a new start with size 0 and stride 0 runs 1-tap windows advancing by 1.
